// File: rtl/delay_pkg.sv
// Shared constants and helpers for the delay_invert_bank family.
// Mode encodings and the inertial counter width function.
package delay_pkg;

   localparam int unsigned MODE_TRANSPORT = 0;
   localparam int unsigned MODE_INERTIAL  = 1;

   // Counter must hold 0..DELAY.
   function automatic int unsigned cnt_width(input int unsigned delay);
      return (delay < 1) ? 1 : $clog2(delay + 1);
   endfunction

endpackage

// File: rtl/delay_invert_bank_if.sv
// Channel bus for delay_invert_bank: enable, inputs, delayed outputs and glitch flags.
// The master drives en/in; the slave (the bank) drives out/glitch.
interface delay_invert_bank_if #(
   parameter int unsigned WIDTH = 8
);

   logic             en;
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] out;
   logic [WIDTH-1:0] glitch;

   modport master (
      output en,
      output in,
      input  out,
      input  glitch
   );

   modport slave (
      input  en,
      input  in,
      output out,
      output glitch
   );

endinterface

// File: rtl/delay_invert_chan.sv
// Single delay channel: a DELAY-stage shift register (transport) or a
// run-length counter that filters short pulses (inertial).
module delay_invert_chan
   import delay_pkg::*;
#(
   parameter int unsigned DELAY    = 26,
   parameter int unsigned INVERT   = 1,
   parameter int unsigned INERTIAL = MODE_TRANSPORT
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic in_i,
   output logic out_o,
   output logic glitch_o
);

   logic t;
   assign t = in_i ^ 1'(INVERT);

   if (INERTIAL == MODE_INERTIAL) begin : gen_inertial
      localparam int unsigned CntW = cnt_width(DELAY);

      logic [CntW-1:0] cnt_q, cnt_d;
      logic            out_q, out_d;
      logic            glitch_q, glitch_d;

      always_comb begin
         cnt_d    = cnt_q;
         out_d    = out_q;
         glitch_d = 1'b0;
         if (en_i) begin
            if (t == out_q) begin
               // Sample returned to the settled level before the run completed.
               glitch_d = (cnt_q != '0);
               cnt_d    = '0;
            end else if (cnt_q == CntW'(DELAY - 1)) begin
               out_d = t;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q    <= '0;
            out_q    <= 1'(INVERT);
            glitch_q <= 1'b0;
         end else begin
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            glitch_q <= glitch_d;
         end
      end

      assign out_o    = out_q;
      assign glitch_o = glitch_q;

   end else begin : gen_transport
      logic [DELAY-1:0] sr_q, sr_d;

      if (DELAY == 1) begin : gen_single
         assign sr_d = en_i ? t : sr_q;
      end else begin : gen_chain
         // The last stage doubles as the output register.
         assign sr_d = en_i ? {sr_q[DELAY-2:0], t} : sr_q;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            sr_q <= {DELAY{1'(INVERT)}};
         end else begin
            sr_q <= sr_d;
         end
      end

      assign out_o    = sr_q[DELAY-1];
      assign glitch_o = 1'b0;
   end

endmodule

// File: rtl/delay_invert_bank.sv
// Multi-channel cycle-counted inverting/buffering delay element.
// WIDTH independent channels sharing clock, reset and enable.
module delay_invert_bank
   import delay_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DELAY    = 26,
   parameter int unsigned INVERT   = 1,
   parameter int unsigned INERTIAL = MODE_TRANSPORT
) (
   input logic                clk,
   input logic                rst,
   delay_invert_bank_if.slave bus
);

   logic [WIDTH-1:0] out_w;
   logic [WIDTH-1:0] glitch_w;

   for (genvar c = 0; c < WIDTH; c++) begin : gen_chan
      delay_invert_chan #(
         .DELAY    (DELAY),
         .INVERT   (INVERT),
         .INERTIAL (INERTIAL)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .en_i     (bus.en),
         .in_i     (bus.in[c]),
         .out_o    (out_w[c]),
         .glitch_o (glitch_w[c])
      );
   end

   assign bus.out    = out_w;
   assign bus.glitch = glitch_w;

endmodule

// File: tb/tb_delay_invert_bank.sv
// Self-checking bench: three bank configurations driven in lockstep and
// compared every cycle against sample-history and run-length models.
module tb_delay_invert_bank;

   localparam int unsigned W = 4;

   logic         clk;
   logic         rst;
   logic         en;
   logic [W-1:0] din;

   int vec_cnt;
   int miscmp_cnt;

   // Reference state.
   logic [W-1:0] samp_q[$];            // transport: every enabled target sample since reset
   logic [W-1:0] b_out, b_gl;          // inertial, DELAY=4, INVERT=1
   int           b_run [W];
   logic [W-1:0] c_out, c_gl;          // inertial, DELAY=1, INVERT=0
   int           c_run [W];

   delay_invert_bank_if #(.WIDTH(W)) ifa ();
   delay_invert_bank_if #(.WIDTH(W)) ifb ();
   delay_invert_bank_if #(.WIDTH(W)) ifc ();

   assign ifa.en = en;
   assign ifa.in = din;
   assign ifb.en = en;
   assign ifb.in = din;
   assign ifc.en = en;
   assign ifc.in = din;

   delay_invert_bank #(.WIDTH(W), .DELAY(4), .INVERT(1), .INERTIAL(0)) u_tr (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   delay_invert_bank #(.WIDTH(W), .DELAY(4), .INVERT(1), .INERTIAL(1)) u_in (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   delay_invert_bank #(.WIDTH(W), .DELAY(1), .INVERT(0), .INERTIAL(1)) u_d1 (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A run of samples differing from the settled level must reach d to switch it.
   function automatic void inert_step(input int d, input logic t, inout logic o,
                                      inout int run, output logic g);
      g = 1'b0;
      if (t == o) begin
         g   = (run > 0);
         run = 0;
      end else begin
         run = run + 1;
         if (run >= d) begin
            o   = t;
            run = 0;
         end
      end
   endfunction

   task automatic model_edge(input logic r, input logic e, input logic [W-1:0] d);
      logic o, g;
      int   rn;
      if (r) begin
         samp_q.delete();
         b_out = {W{1'b1}};
         b_gl  = '0;
         c_out = '0;
         c_gl  = '0;
         for (int c = 0; c < W; c++) begin
            b_run[c] = 0;
            c_run[c] = 0;
         end
      end else if (e) begin
         samp_q.push_back(~d);
         for (int c = 0; c < W; c++) begin
            o = b_out[c]; rn = b_run[c];
            inert_step(4, ~d[c], o, rn, g);
            b_out[c] = o; b_run[c] = rn; b_gl[c] = g;
            o = c_out[c]; rn = c_run[c];
            inert_step(1, d[c], o, rn, g);
            c_out[c] = o; c_run[c] = rn; c_gl[c] = g;
         end
      end else begin
         b_gl = '0;
         c_gl = '0;
      end
   endtask

   task automatic check_all();
      logic [W-1:0] exp_a;
      int           n;
      n     = samp_q.size();
      exp_a = (n >= 4) ? samp_q[n-4] : {W{1'b1}};
      vec_cnt++;
      assert (ifa.out === exp_a) else begin
         miscmp_cnt++;
         $error("FAIL tr_out: observed %h expected %h", ifa.out, exp_a);
      end
      vec_cnt++;
      assert (ifa.glitch === 4'h0) else begin
         miscmp_cnt++;
         $error("FAIL tr_glitch: observed %h expected 0", ifa.glitch);
      end
      vec_cnt++;
      assert (ifb.out === b_out) else begin
         miscmp_cnt++;
         $error("FAIL in_out: observed %h expected %h", ifb.out, b_out);
      end
      vec_cnt++;
      assert (ifb.glitch === b_gl) else begin
         miscmp_cnt++;
         $error("FAIL in_glitch: observed %h expected %h", ifb.glitch, b_gl);
      end
      vec_cnt++;
      assert (ifc.out === c_out) else begin
         miscmp_cnt++;
         $error("FAIL d1_out: observed %h expected %h", ifc.out, c_out);
      end
      vec_cnt++;
      assert (ifc.glitch === c_gl) else begin
         miscmp_cnt++;
         $error("FAIL d1_glitch: observed %h expected %h", ifc.glitch, c_gl);
      end
   endtask

   // Drive inputs away from the edge, clock once, check on the falling edge.
   task automatic tick(input logic r, input logic e, input logic [W-1:0] d);
      rst = r;
      en  = e;
      din = d;
      @(posedge clk);
      model_edge(r, e, d);
      @(negedge clk);
      check_all();
   endtask

   initial begin
      logic [W-1:0] cur;
      vec_cnt    = 0;
      miscmp_cnt = 0;
      rst = 1'b1;
      en  = 1'b1;
      din = 4'hF;

      // Reset held with all inputs high, then released with inputs low.
      tick(1'b1, 1'b1, 4'hF);
      tick(1'b1, 1'b1, 4'hF);
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 4'h0);
      vec_cnt++;
      assert (ifa.out === 4'hF) else begin
         miscmp_cnt++;
         $error("FAIL rst_hold: observed %h expected f", ifa.out);
      end

      // Rising edge on ch0, then a one-cycle pulse on ch1.
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 4'h1);
      tick(1'b0, 1'b1, 4'h3);
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b1, 4'h1);

      // ch2: 3-cycle pulse (filtered in inertial), then 4-cycle pulse (passes).
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 4'h5);
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 4'h1);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 4'h5);
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 4'h1);

      // ch3 rises, then enable drops mid-flight.
      tick(1'b0, 1'b1, 4'h9);
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 4'h9);
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 4'h9);

      // Inertial count frozen by en low, then resumed.
      for (int i = 0; i < 2; i++) tick(1'b0, 1'b1, 4'hD);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 4'hD);

      // Reset mid-flight discards in-flight edges.
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 4'h0);
      tick(1'b0, 1'b1, 4'hF);
      tick(1'b0, 1'b1, 4'hF);
      tick(1'b1, 1'b0, 4'hF);
      for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 4'h0);

      // Toggle every cycle.
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, (i % 2 == 0) ? 4'hF : 4'h0);

      // Randomized: sticky inputs so runs of various lengths occur.
      cur = 4'h0;
      for (int i = 0; i < 1500; i++) begin
         for (int c = 0; c < W; c++) begin
            if ($urandom_range(0, 99) < 30) cur[c] = ~cur[c];
         end
         tick(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
              ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0, cur);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
      $finish;
   end

endmodule
